// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note sequencer slice:
//   - note code constants NOTE_A..NOTE_G and NOTE_REST
//   - sequencer state enum (IDLE / PLAY / GAP)
//   - default note and gap durations (in clk cycles at 100 MHz)
//   - max_int helper used to size the shared duration counter
// ---------------------------------------------------------------------------
package note_pkg;

  localparam logic [2:0] NOTE_A    = 3'd0;
  localparam logic [2:0] NOTE_B    = 3'd1;
  localparam logic [2:0] NOTE_C    = 3'd2;
  localparam logic [2:0] NOTE_D    = 3'd3;
  localparam logic [2:0] NOTE_E    = 3'd4;
  localparam logic [2:0] NOTE_F    = 3'd5;
  localparam logic [2:0] NOTE_G    = 3'd6;
  localparam logic [2:0] NOTE_REST = 3'd7;

  // 250 ms note, 25 ms silence at 100 MHz
  localparam int NOTE_CYCLES_DEF = 25_000_000;
  localparam int GAP_CYCLES_DEF  = 2_500_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// ---------------------------------------------------------------------------
// note_fifo
// Parameterised synchronous circular-buffer FIFO.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (pointers/count only)
//   push, din      write request and data; ignored while full
//   pop            read request; ignored while empty
//   dout           head entry, combinational from storage
//   count          occupancy, $clog2(DEPTH)+1 bits
//   full, empty    derived from the registered count
// ---------------------------------------------------------------------------
module note_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide, so they wrap at DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Queues keypad note requests and plays them one after another on the
// speaker: each note sounds for NOTE_CYCLES, followed by GAP_CYCLES of
// silence. Code 7 is a rest (silent, same timing).
// Ports:
//   clk, rst_n   100 MHz clock, asynchronous active-low reset
//   note_valid   request strobe; accepted when note_ready is high
//   note_code    0..6 = A..G, 7 = rest
//   note_ready   FIFO not full
//   tone_clks    tone clocks from the divider, bit i = note code i
//   spk          registered speaker drive
//   busy         state is not IDLE
//   cur_note     code currently playing (valid while busy)
//   fifo_count   FIFO occupancy
//   overflow     sticky: a request arrived while full
// ---------------------------------------------------------------------------
module note_sequencer
  import note_pkg::*;
#(
  parameter int NOTE_CYCLES = NOTE_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     note_valid,
  input  logic [2:0]               note_code,
  output logic                     note_ready,
  input  logic [6:0]               tone_clks,
  output logic                     spk,
  output logic                     busy,
  output logic [2:0]               cur_note,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int DUR_W = $clog2(max_int(NOTE_CYCLES, GAP_CYCLES));

  localparam logic [DUR_W-1:0] NOTE_LOAD = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD  = DUR_W'(GAP_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Reset: assertion is immediate, release is re-timed to clk so every
  // flop leaves reset on the same edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // -------------------------------------------------------------------------
  // Note FIFO
  // -------------------------------------------------------------------------
  logic          fifo_push, fifo_pop;
  logic [2:0]    fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;

  assign fifo_push = note_valid && note_ready;

  note_fifo #(
    .DEPTH (DEPTH),
    .W     (3)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_int_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (note_code),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign note_ready = !fifo_full;
  assign fifo_count = fifo_cnt;

  // Sticky overflow. Uses registered full, so a pop in the same cycle does
  // not rescue the request.
  logic overflow_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                    overflow_q <= 1'b0;
    else if (note_valid && fifo_full)  overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  seq_state_e       state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [2:0]       cur_q, cur_d;
  logic             spk_q, spk_d;

  // State register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      dur_q   <= '0;
      cur_q   <= NOTE_A;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      cur_q   <= cur_d;
      spk_q   <= spk_d;
    end
  end

  // Next-state logic. The empty test looks at the registered count, so a
  // push landing on a decision edge is picked up one cycle later.
  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          dur_d    = NOTE_LOAD;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (dur_q == '0) begin
          dur_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
      GAP: begin
        if (dur_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            dur_d    = NOTE_LOAD;
            state_d  = PLAY;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dur_d   = '0;
      end
    endcase
  end

  // Tone mux: one gated term per tone bit. There is no term for code 7,
  // so a rest selects nothing and stays silent.
  logic [6:0] tone_hit;

  for (genvar gi = 0; gi < 7; gi++) begin : g_tone
    assign tone_hit[gi] = (cur_q == 3'(gi)) && tone_clks[gi];
  end

  // Output logic
  always_comb begin
    spk_d = (state_q == PLAY) && (|tone_hit);
    busy  = (state_q != IDLE);
  end

  assign spk      = spk_q;
  assign cur_note = cur_q;

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
// Directed bench for note_sequencer with NOTE_CYCLES=10, GAP_CYCLES=3,
// DEPTH=4. Tone clocks come from a local divider (bit i toggles every i+2
// cycles). Requests are queued in push_q and driven one per cycle by tick().
// ---------------------------------------------------------------------------
module tb_note_sequencer;
  import note_pkg::*;

  localparam int NC = 10;
  localparam int GC = 3;
  localparam int DP = 4;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          note_valid = 1'b0;
  logic [2:0]    note_code = 3'd0;
  logic          note_ready;
  logic [6:0]    tone_clks = 7'd0;
  logic          spk;
  logic          busy;
  logic [2:0]    cur_note;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] tone_e = 7'd0;   // tone_clks as seen at the last rising edge
  logic [2:0] push_q [$];
  int         div_cnt [7] = '{default: 0};

  note_sequencer #(
    .NOTE_CYCLES (NC),
    .GAP_CYCLES  (GC),
    .DEPTH       (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_code  (note_code),
    .note_ready (note_ready),
    .tone_clks  (tone_clks),
    .spk        (spk),
    .busy       (busy),
    .cur_note   (cur_note),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Tone divider: changes on the falling edge so it is stable at posedge.
  always @(negedge clk) begin
    for (int i = 0; i < 7; i++) begin
      if (div_cnt[i] == i + 1) begin
        div_cnt[i]   <= 0;
        tone_clks[i] <= ~tone_clks[i];
      end else begin
        div_cnt[i] <= div_cnt[i] + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive the next queued request (if any), advance one edge, sample at +1.
  task automatic tick();
    if (push_q.size() > 0) begin
      note_valid = 1'b1;
      note_code  = push_q.pop_front();
    end else begin
      note_valid = 1'b0;
    end
    @(posedge clk);
    tone_e = tone_clks;
    #1;
    note_valid = 1'b0;
  endtask

  // Phase k (1..NC+GC) after PLAY entry. Edges 1..NC show the tone of the
  // current note; edges NC+1..NC+GC are silent; busy after the last edge
  // depends on whether another note is queued.
  task automatic play_tick(input int k, input logic [2:0] code, input logic more);
    logic exp_spk;
    int   idx;
    tick();
    idx = int'(code);
    exp_spk = 1'b0;
    if (k <= NC && code != NOTE_REST) exp_spk = tone_e[idx];
    check_val($sformatf("spk_n%0d_k%0d", code, k), 32'(spk), 32'(exp_spk));
    if (k == NC + GC) check_val($sformatf("busy_end_n%0d", code), 32'(busy), 32'(more));
    else              check_val($sformatf("busy_n%0d_k%0d", code, k), 32'(busy), 32'd1);
  endtask

  // Called on the edge where PLAY was entered.
  task automatic play_note(input logic [2:0] code, input logic more);
    check_val("entry_busy", 32'(busy), 32'd1);
    check_val("entry_cur", 32'(cur_note), 32'(code));
    for (int k = 1; k <= NC + GC; k++) play_tick(k, code, more);
  endtask

  initial begin
    // ---- reset state ----
    repeat (3) tick();
    check_val("rst_spk", 32'(spk), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_cnt", 32'(fifo_count), 32'd0);
    check_val("rst_ready", 32'(note_ready), 32'd1);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_cur", 32'(cur_note), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_val("idle_spk", 32'(spk), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_ready", 32'(note_ready), 32'd1);
      check_val("idle_cnt", 32'(fifo_count), 32'd0);
    end

    // ---- single note C ----
    push_q.push_back(NOTE_C);
    tick();
    check_val("c_cnt_push", 32'(fifo_count), 32'd1);
    check_val("c_busy_push", 32'(busy), 32'd0);
    tick();
    check_val("c_cnt_pop", 32'(fifo_count), 32'd0);
    play_note(NOTE_C, 1'b0);

    // ---- A, rest, G back to back ----
    push_q.push_back(NOTE_A);
    push_q.push_back(NOTE_REST);
    push_q.push_back(NOTE_G);
    tick();
    tick();
    play_note(NOTE_A, 1'b1);
    play_note(NOTE_REST, 1'b1);
    play_note(NOTE_G, 1'b0);

    // ---- fill FIFO and overflow ----
    push_q.push_back(NOTE_B);
    tick();
    tick();
    check_val("ovf_entry_cur", 32'(cur_note), 32'(NOTE_B));
    push_q.push_back(NOTE_D);
    push_q.push_back(NOTE_E);
    push_q.push_back(NOTE_F);
    push_q.push_back(NOTE_A);
    push_q.push_back(NOTE_G);   // arrives while full: dropped
    for (int k = 1; k <= 5; k++) begin
      play_tick(k, NOTE_B, 1'b1);
      check_val($sformatf("ovf_cnt_k%0d", k), 32'(fifo_count), (k < 5) ? 32'(k) : 32'd4);
      check_val($sformatf("ovf_ready_k%0d", k), 32'(note_ready), (k >= 4) ? 32'd0 : 32'd1);
      check_val($sformatf("ovf_flag_k%0d", k), 32'(overflow), (k == 5) ? 32'd1 : 32'd0);
    end
    for (int k = 6; k <= NC + GC; k++) play_tick(k, NOTE_B, 1'b1);
    check_val("ovf_cnt_after_pop", 32'(fifo_count), 32'd3);
    check_val("ovf_ready_after_pop", 32'(note_ready), 32'd1);
    check_val("ovf_sticky", 32'(overflow), 32'd1);
    play_note(NOTE_D, 1'b1);
    play_note(NOTE_E, 1'b1);
    play_note(NOTE_F, 1'b1);
    play_note(NOTE_A, 1'b0);    // G was dropped, so the block goes idle here
    check_val("ovf_final_cnt", 32'(fifo_count), 32'd0);

    // ---- reset mid-PLAY with 3 queued ----
    push_q.push_back(NOTE_C);
    tick();
    tick();
    check_val("mid_entry_busy", 32'(busy), 32'd1);
    push_q.push_back(NOTE_E);
    push_q.push_back(NOTE_F);
    push_q.push_back(NOTE_G);
    for (int k = 1; k <= 5; k++) play_tick(k, NOTE_C, 1'b1);
    check_val("mid_pre_cnt", 32'(fifo_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_spk", 32'(spk), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_cnt", 32'(fifo_count), 32'd0);
    check_val("mid_rst_ready", 32'(note_ready), 32'd1);
    check_val("mid_rst_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_val("post_rst_busy", 32'(busy), 32'd0);
      check_val("post_rst_spk", 32'(spk), 32'd0);
      check_val("post_rst_cnt", 32'(fifo_count), 32'd0);
    end

    // ---- push exactly when GAP ends with an empty FIFO ----
    push_q.push_back(NOTE_F);
    tick();
    tick();
    check_val("ge_entry_cur", 32'(cur_note), 32'(NOTE_F));
    for (int k = 1; k < NC + GC; k++) play_tick(k, NOTE_F, 1'b0);
    push_q.push_back(NOTE_B);
    play_tick(NC + GC, NOTE_F, 1'b0);   // block falls to IDLE on this edge
    check_val("ge_cnt_idle", 32'(fifo_count), 32'd1);
    tick();
    play_note(NOTE_B, 1'b0);
    check_val("ge_final_cnt", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
